gf2m_alu_scheduler: RTL



---
 rtl/gf2m_alu_pkg.sv | 34 +++
 rtl/rr_arbiter_2.sv | 23 ++
 rtl/gf2m_alu_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/gf2m_alu_pkg.sv
// Opcodes, FSM encoding and latency lookup shared by the GF(2^m) ALU scheduler.
package gf2m_alu_pkg;

  localparam logic [2:0] OP_NONE   = 3'b000;
  localparam logic [2:0] OP_MUL    = 3'b001;
  localparam logic [2:0] OP_SQR    = 3'b010;
  localparam logic [2:0] OP_XOR256 = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b111;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } sched_state_e;

  // Unknown opcodes fall back to the XOR hold time.
  function automatic int unsigned op_latency(input logic [2:0]  op,
                                             input int unsigned mul_cyc,
                                             input int unsigned sqr_cyc,
                                             input int unsigned xor_cyc);
    case (op)
      OP_MUL:  return mul_cyc;
      OP_SQR:  return sqr_cyc;
      default: return xor_cyc;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_SQR) || (op == OP_XOR256) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last is granted.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant
);

  logic last_grant;

  assign grant = req[1] & (~req[0] | ~last_grant);

  // Reset value 1 makes the first tie go to requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/gf2m_alu_scheduler.sv
// Shares one external combinational GF(2^m) ALU between two requesters with multicycle hold.
// Optional opcode checking is enabled by defining GF2M_SCHED_OP_CHECK_EN.
//
// state  | meaning
// S_IDLE | arbitrating, ready to accept one request
// S_WAIT | operands held on the ALU, cnt counting down to capture
// S_RESP | result registered, waiting for rsp_ready
module gf2m_alu_scheduler
  import gf2m_alu_pkg::*;
#(
  parameter int unsigned MUL_CYC = 4,
  parameter int unsigned SQR_CYC = 2,
  parameter int unsigned XOR_CYC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [255:0] req0_a,
  input  logic [255:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [255:0] req1_a,
  input  logic [255:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic [135:0] rsp_c,
  output logic [127:0] rsp_d,
  output logic [2:0]   alu_sel,
  output logic [255:0] alu_a,
  output logic [255:0] alu_b,
  input  logic [135:0] alu_c,
  input  logic [127:0] alu_d
);

  sched_state_e     state_q, state_d;
  logic             grant;
  logic             accept;
  logic             issue_ok;
  logic [2:0]       sel_op;
  logic [255:0]     sel_a, sel_b;
  logic [CNT_W-1:0] cnt_q;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .update (accept),
    .grant  (grant)
  );

  assign sel_op    = grant ? req1_op : req0_op;
  assign sel_a     = grant ? req1_a  : req0_a;
  assign sel_b     = grant ? req1_b  : req0_b;
  assign rsp_valid = (state_q == S_RESP);

`ifdef GF2M_SCHED_OP_CHECK_EN
  logic err_q;

  assign issue_ok = op_legal(sel_op);
  assign rsp_err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= ~issue_ok;
    end
  end
`else
  assign issue_ok = 1'b1;
  assign rsp_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = issue_ok ? S_WAIT : S_RESP;
      S_WAIT: if (cnt_q == '0) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is a function of state and the valids only, never of rsp_ready.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    if (state_q == S_IDLE) begin
      req0_ready = ~grant;
      req1_ready = grant;
      accept     = req0_valid | req1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_sel <= OP_NONE;
      alu_a   <= '0;
      alu_b   <= '0;
      cnt_q   <= '0;
      rsp_id  <= 1'b0;
      rsp_c   <= '0;
      rsp_d   <= '0;
    end else if (accept) begin
      rsp_id <= grant;
      if (issue_ok) begin
        alu_sel <= sel_op;
        alu_a   <= sel_a;
        alu_b   <= sel_b;
        cnt_q   <= CNT_W'(op_latency(sel_op, MUL_CYC, SQR_CYC, XOR_CYC) - 1);
      end else begin
        rsp_c <= '0;
        rsp_d <= '0;
      end
    end else if (state_q == S_WAIT) begin
      // Capture on the last hold cycle, then park the ALU inputs.
      if (cnt_q == '0) begin
        rsp_c   <= alu_c;
        rsp_d   <= alu_d;
        alu_sel <= OP_NONE;
        alu_a   <= '0;
        alu_b   <= '0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule
